bin_reader: RTL and testbench

Streams one bin of words out of the bin-manager block RAM to the downstream clause consumer. On a start command it walks `len_i` consecutive addresses from `base_addr_i` on the RAM's port-B read side, absorbs the RAM's one-cycle registered read latency, and presents the words on a valid/ready stream with a last-beat flag. A small internal FIFO with credit accounting lets the stream stall at any cycle without losing in-flight read data.

---
 rtl/bin_reader.sv | 130 +++++++++++++
 tb/tb_bin_reader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bin_reader.sv
// Streams len_i consecutive words from a RAM with one-cycle registered read
// latency onto a valid/ready stream, using a small credit-checked output FIFO.
module bin_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH:0]     rem_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    issue_q, issue_last_q;
    logic                    inflight_q, inflight_last_q;
    logic                    busy_q, done_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    push, pop, can_issue;
    logic [CW:0]             occ;

    // An address is on the bus for one cycle (issue_q), then its data arrives the
    // next cycle (inflight_q): both stages already own a FIFO slot.
    assign occ       = {1'b0, count_q} + (CW+1)'(issue_q) + (CW+1)'(inflight_q);
    assign can_issue = occ < (CW+1)'(FIFO_DEPTH);
    assign push      = inflight_q;

    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = fifo_data_q[rd_ptr_q];
    assign out_last_o  = out_valid_o && fifo_last_q[rd_ptr_q];

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_addr_o = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            rem_q           <= '0;
            addr_q          <= '0;
            issue_q         <= 1'b0;
            issue_last_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            issue_q         <= 1'b0;
            issue_last_q    <= 1'b0;
            inflight_q      <= issue_q;
            inflight_last_q <= issue_last_q;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q       <= base_addr_i;
                            issue_q      <= 1'b1;
                            issue_last_q <= (len_i == LEN_ONE);
                            rem_q        <= len_i - LEN_ONE;
                            busy_q       <= 1'b1;
                            state_q      <= (len_i == LEN_ONE) ? DRAIN : READ;
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        addr_q       <= addr_q + 1'b1;
                        issue_q      <= 1'b1;
                        issue_last_q <= (rem_q == LEN_ONE);
                        rem_q        <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last_o) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_data_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_reader.sv
// Directed + randomized bench for bin_reader: RAM model with registered read and
// a queue of expected beats derived from base/len.
module tb_bin_reader;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int FD = 4;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy_o, done_o, out_valid_o, out_last_o;
    logic          out_ready = 1'b1;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] out_data_o;

    logic [DW-1:0] ram [NW];
    int checks = 0;
    int failures = 0;

    bin_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .len_i(len),
        .busy_o(busy_o), .done_o(done_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .out_last_o(out_last_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= ram[mem_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: 1,0,0,1 pattern plus a 10-cycle stall; 2: random
    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            if (k >= 8 && k < 18) return 1'b0;
            return ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_bin(input int b, input int l, input int mode, input bit dbl_start);
        logic [DW-1:0] q_data[$];
        bit            q_last[$];
        logic [DW-1:0] prev_d;
        bit            prev_stall, fin, done_exp;
        int            dones, tail, budget;
        prev_d = '0; prev_stall = 0; fin = 0; dones = 0; tail = 0;
        done_exp = (l == 0);
        budget = 8 * l + 60;
        for (int i = 0; i < l; i++) begin
            q_data.push_back(ram[(b + i) % NW]);
            q_last.push_back(i == l - 1);
        end
        @(negedge clk);
        start = 1'b1; base = AW'(b); len = (AW+1)'(l); out_ready = ready_for(mode, 0);
        for (int k = 1; k <= budget && tail < 5; k++) begin
            @(negedge clk);
            start = dbl_start && (k == 3);
            if (start) begin base = '0; len = (AW+1)'(2); end
            chk("done", 32'(done_o), 32'(done_exp));
            chk("busy", 32'(busy_o), 32'(l > 0 && !fin));
            if (k <= 2) chk("latency_valid_low", 32'(out_valid_o), 0);
            if (k == 3 && l > 0) chk("first_valid", 32'(out_valid_o), 1);
            if (mode == 0 && k <= l && l <= 8) chk("mem_addr", 32'(mem_addr_o), 32'((b + k - 1) % NW));
            if (out_valid_o) begin
                if (q_data.size() == 0) chk("extra_beat", 32'(out_valid_o), 0);
                else begin
                    chk("data", 32'(out_data_o), 32'(q_data[0]));
                    chk("last", 32'(out_last_o), 32'(q_last[0]));
                    if (prev_stall) chk("stall_stable", 32'(out_data_o), 32'(prev_d));
                end
            end else if (mode == 0 && k >= 3 && q_data.size() > 0) begin
                chk("throughput_gap", 32'(out_valid_o), 1);
            end
            if (done_o) dones++;
            out_ready  = ready_for(mode, k);
            prev_stall = out_valid_o && !out_ready;
            prev_d     = out_data_o;
            done_exp   = 0;
            if (out_valid_o && out_ready && q_data.size() > 0) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
                if (q_data.size() == 0) begin fin = 1; done_exp = 1; end
            end
            if (fin || l == 0) tail++;
        end
        start = 1'b0;
        chk("done_count", 32'(dones), 1);
        chk("beats_left", 32'(q_data.size()), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NW; i++) ram[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) ram[8 + i] = DW'(16'hA0 + i);

        #3 rst = 1'b0;
        #3;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_last", 32'(out_last_o), 0);
        chk("rst_data", 32'(out_data_o), 0);
        chk("rst_addr", 32'(mem_addr_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_bin(8, 4, 0, 0);      // basic bin 0xA0..0xA3
        run_bin(40, 8, 1, 0);     // backpressure
        run_bin(5, 0, 0, 0);      // zero length
        run_bin(1022, 4, 0, 0);   // address wrap
        run_bin(300, 6, 0, 1);    // start while busy
        run_bin(700, 1, 0, 0);    // single word
        for (int t = 0; t < 6; t++)
            run_bin(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 12)), 2, 0);
        run_bin(int'($urandom_range(0, NW - 1)), NW, 2, 0);

        // reset in the middle of a 6-word bin
        @(negedge clk);
        start = 1'b1; base = AW'(100); len = (AW+1)'(6); out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid_o && out_ready) n++;
        end
        chk("pre_reset_beats", 32'(n), 2);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_done", 32'(done_o), 0);
        chk("midrst_valid", 32'(out_valid_o), 0);
        chk("midrst_last", 32'(out_last_o), 0);
        chk("midrst_data", 32'(out_data_o), 0);
        chk("midrst_addr", 32'(mem_addr_o), 0);
        @(negedge clk);
        rst = 1'b1;
        run_bin(0, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
